// File: rtl/lhn_simd_alu_v.sv
// lhn_simd_alu_v: parametrised SIMD execute unit for lhnRISC.
// Single-cycle ALU/shift/MUL/vector ops, an iterative restoring divider
// and a valid/ready handshake on both the request and the result side.
// Optional build macro LHN_ALU_SAT_EN: VADD/VSUB saturate per lane.

// One vector lane: add/sub at width LW with {C,N,V,Z} flags.
module lhn_simd_alu_v_lane #(
  parameter int LW = 7
) (
  input  logic [LW-1:0] i_a,
  input  logic [LW-1:0] i_b,
  input  logic          i_sub,
  output logic [LW-1:0] o_r,
  output logic [3:0]    o_flg
);
  logic [LW:0]   w_sum;
  logic          w_v;
  logic [LW-1:0] w_res;

  // Raw lane arithmetic; bit LW is carry for add and borrow for sub.
  always_comb begin
    w_sum = i_sub ? ({1'b0, i_a} - {1'b0, i_b}) : ({1'b0, i_a} + {1'b0, i_b});
    w_v   = i_sub ? ((i_a[LW-1] != i_b[LW-1]) && (w_sum[LW-1] != i_a[LW-1]))
                  : ((i_a[LW-1] == i_b[LW-1]) && (w_sum[LW-1] != i_a[LW-1]));
  end

`ifdef LHN_ALU_SAT_EN
  // On overflow the true result lies beyond the limit on the side of ta's sign.
  always_comb begin
    w_res = w_sum[LW-1:0];
    if (w_v) w_res = i_a[LW-1] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}};
  end
`else
  assign w_res = w_sum[LW-1:0];
`endif

  assign o_r   = w_res;
  assign o_flg = {w_sum[LW], w_res[LW-1], w_v, (w_res == '0)};
endmodule

module lhn_simd_alu_v #(
  parameter int DW    = 14,
  parameter int LANES = 2,
  parameter int SW    = 4
) (
  input  logic               Clock_pin,
  input  logic               Reset_pin,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [DW-1:0]      ta,
  input  logic [DW-1:0]      tb,
  input  logic [3:0]         sr_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      res_h,
  output logic [DW-1:0]      res_l,
  output logic [4*LANES-1:0] sr_out
);
  localparam int LW = DW / LANES;
  localparam int CW = $clog2(DW + 1);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_ADDC = 4'd2,  OP_SUBC = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4,  OP_DIV  = 4'd5,  OP_AND  = 4'd6,  OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8,  OP_NOT  = 4'd9,  OP_SRL  = 4'd10, OP_SRA  = 4'd11;
  localparam logic [3:0] OP_ROTL = 4'd12, OP_ROTR = 4'd13, OP_VADD = 4'd14, OP_VSUB = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_DIV_RUN, S_HOLD} state_t;

  state_t               r_state;
  logic                 r_out_valid;
  logic [DW-1:0]        r_res_h, r_res_l;
  logic [4*LANES-1:0]   r_sr;
  logic [DW-1:0]        r_quo, r_rem, r_dvs;
  logic [CW-1:0]        r_cnt;

  logic                 w_accept;
  logic                 w_cin, w_sub;
  logic [DW:0]          w_as;
  logic                 w_as_v;
  logic [2*DW-1:0]      w_prod;
  logic [31:0]          w_amt32;
  logic [SW-1:0]        w_amt;
  logic [DW:0]          w_shx;
  logic [2*DW-1:0]      w_dbl_l, w_dbl_r;
  logic [DW-1:0]        w_res_h, w_res_l;
  logic [3:0]           w_flg;
  logic [4*LANES-1:0]   w_sr;
  logic [LANES-1:0][LW-1:0] w_vres;
  logic [LANES-1:0][3:0]    w_vflg;
  logic [DW:0]          w_shf, w_dif;
  logic                 w_ge;

  assign in_ready  = !Reset_pin && (r_state != S_DIV_RUN) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign res_h     = r_res_h;
  assign res_l     = r_res_l;
  assign sr_out    = r_sr;

  // Vector lanes, independent carries.
  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      lhn_simd_alu_v_lane #(.LW(LW)) u_lane (
        .i_a   (ta[LW*k +: LW]),
        .i_b   (tb[LW*k +: LW]),
        .i_sub (op == OP_VSUB),
        .o_r   (w_vres[k]),
        .o_flg (w_vflg[k])
      );
    end
  endgenerate

  // Shared datapath pieces: scalar add/sub with carry-in, product, shifter.
  always_comb begin
    w_sub   = (op == OP_SUB) || (op == OP_SUBC);
    w_cin   = ((op == OP_ADDC) || (op == OP_SUBC)) && sr_in[3];
    w_as    = w_sub ? ({1'b0, ta} - {1'b0, tb} - {{DW{1'b0}}, w_cin})
                    : ({1'b0, ta} + {1'b0, tb} + {{DW{1'b0}}, w_cin});
    w_as_v  = w_sub ? ((ta[DW-1] != tb[DW-1]) && (w_as[DW-1] != ta[DW-1]))
                    : ((ta[DW-1] == tb[DW-1]) && (w_as[DW-1] != ta[DW-1]));
    w_prod  = {{DW{1'b0}}, ta} * {{DW{1'b0}}, tb};
    w_amt32 = 32'(tb[SW-1:0]) % DW;
    w_amt   = w_amt32[SW-1:0];
    // Bit 0 of {ta,0}>>amt is the last bit shifted out (0 when amt==0).
    w_shx   = {ta, 1'b0} >> w_amt;
    w_dbl_l = {ta, ta} << w_amt;
    w_dbl_r = {ta, ta} >> w_amt;
  end

  // Result/flag select for every single-cycle op.
  always_comb begin
    w_res_h = '0;
    w_res_l = '0;
    w_flg   = '0;
    w_sr    = '0;
    case (op)
      OP_ADD, OP_SUB, OP_ADDC, OP_SUBC: begin
        w_res_h = w_as[DW-1:0];
        w_flg   = {w_as[DW], w_as[DW-1], w_as_v, (w_as[DW-1:0] == '0)};
      end
      OP_MUL: begin
        w_res_h = w_prod[DW-1:0];
        w_res_l = w_prod[2*DW-1:DW];
        w_flg   = {(w_res_l != '0), w_res_h[DW-1], (w_res_l != '0), (w_prod == '0)};
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ROTL, OP_ROTR: begin
        case (op)
          OP_AND:  w_res_h = ta & tb;
          OP_OR:   w_res_h = ta | tb;
          OP_XOR:  w_res_h = ta ^ tb;
          OP_NOT:  w_res_h = ~ta;
          OP_ROTL: w_res_h = w_dbl_l[2*DW-1:DW];
          default: w_res_h = w_dbl_r[DW-1:0];
        endcase
        w_flg = {sr_in[3], w_res_h[DW-1], sr_in[1], (w_res_h == '0)};
      end
      OP_SRL, OP_SRA: begin
        w_res_h = (op == OP_SRA) ? DW'($signed(ta) >>> w_amt) : (ta >> w_amt);
        w_flg   = {w_shx[0], w_res_h[DW-1], sr_in[1], (w_res_h == '0)};
      end
      default: ;
    endcase
    if (op == OP_VADD || op == OP_VSUB) begin
      w_res_h = w_vres;
      w_sr    = w_vflg;
    end else begin
      w_sr[3:0] = w_flg;
    end
  end

  // Divider step: restoring shift-subtract, one quotient bit per cycle.
  always_comb begin
    w_shf = {r_rem, r_quo[DW-1]};
    w_ge  = (w_shf >= {1'b0, r_dvs});
    w_dif = w_shf - {1'b0, r_dvs};
  end

  // Control FSM with registered result, flags and valid.
  always_ff @(posedge Clock_pin) begin
    if (Reset_pin) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_res_h     <= '0;
      r_res_l     <= '0;
      r_sr        <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
    end else if (r_state == S_DIV_RUN) begin
      if (r_cnt != CW'(DW)) begin
        r_rem <= w_ge ? w_dif[DW-1:0] : w_shf[DW-1:0];
        r_quo <= {r_quo[DW-2:0], w_ge};
        r_cnt <= r_cnt + 1'b1;
      end else begin
        // Divide by zero falls out as quotient all ones, remainder ta.
        r_res_h     <= r_quo;
        r_res_l     <= r_rem;
        r_sr        <= '0;
        r_sr[3:0]   <= {1'b0, 1'b0, (r_dvs == '0), (r_quo == '0)};
        r_out_valid <= 1'b1;
        r_state     <= S_HOLD;
      end
    end else if (w_accept) begin
      if (op == OP_DIV) begin
        r_quo       <= ta;
        r_rem       <= '0;
        r_dvs       <= tb;
        r_cnt       <= '0;
        r_out_valid <= 1'b0;
        r_state     <= S_DIV_RUN;
      end else begin
        r_res_h     <= w_res_h;
        r_res_l     <= w_res_l;
        r_sr        <= w_sr;
        r_out_valid <= 1'b1;
        r_state     <= S_HOLD;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_state     <= S_IDLE;
    end
  end
endmodule
